mux2_rr_arbiter: RTL

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/mux2_bus.sv | 23 ++
 rtl/mux2_rr_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared definitions for the two-requester round-robin channel
//               arbiter: default widths, burst-counter width and the
//               arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int unsigned c_DEFAULT_W         = 8;
    localparam int unsigned c_DEFAULT_MAX_BURST = 4;
    localparam int unsigned c_CNT_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux2_bus.sv
`default_nettype none
// ============================================================================
// Module      : mux2_bus
// Description : W-bit 2:1 data multiplexer, purely combinational.
// Ports       : S  - select (0 = A, 1 = B)
//               A  - input word A
//               B  - input word B
//               X  - selected word
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_bus #(
    parameter int unsigned W = 8
) (
    input  logic         S,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] X
);

    assign X = S ? B : A;

endmodule : mux2_bus
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_arbiter
// Description : Round-robin arbiter granting one shared output channel to
//               one of two requesters, with a bounded burst length while the
//               other side is waiting and direct (bubble-free) handover.
// Ports       : CLK    - clock, rising edge
//               RST_N  - asynchronous active-low reset
//               REQ_A  - requester A has data pending
//               DATA_A - requester A data
//               REQ_B  - requester B has data pending
//               DATA_B - requester B data
//               READY  - downstream accepts DATA_X this cycle
//               GNT_A  - A owns the channel
//               GNT_B  - B owns the channel
//               S      - data select (0 = A, 1 = B)
//               VALID  - DATA_X carries a valid word
//               DATA_X - selected data
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W         = c_DEFAULT_W,
    parameter int unsigned MAX_BURST = c_DEFAULT_MAX_BURST   // legal 1..15
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         REQ_A,
    input  logic [W-1:0] DATA_A,
    input  logic         REQ_B,
    input  logic [W-1:0] DATA_B,
    input  logic         READY,
    output logic         GNT_A,
    output logic         GNT_B,
    output logic         S,
    output logic         VALID,
    output logic [W-1:0] DATA_X
);

    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic               last_q,  last_d;    // 0 = A served last, 1 = B
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;

    logic               w_valid;
    logic               w_xfer;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_burst_done;

    assign w_valid      = ((state_q == ST_OWN_A) && REQ_A) ||
                          ((state_q == ST_OWN_B) && REQ_B);
    // READY only matters when a word is actually on offer.
    assign w_xfer       = w_valid && READY;
    assign w_cnt_inc    = cnt_q + 1'b1;
    assign w_burst_done = w_xfer && (w_cnt_inc == c_MAX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;        // pretend B was last so A wins the first tie
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ_A && REQ_B) begin
                    state_d = last_q ? ST_OWN_A : ST_OWN_B;
                end else if (REQ_A) begin
                    state_d = ST_OWN_A;
                end else if (REQ_B) begin
                    state_d = ST_OWN_B;
                end
            end

            ST_OWN_A: begin
                // A dropping its request abandons any unaccepted word.
                if (!REQ_A) begin
                    state_d = REQ_B ? ST_OWN_B : ST_IDLE;
                end else if (w_xfer) begin
                    if (w_burst_done) begin
                        cnt_d = '0;
                        if (REQ_B) begin
                            state_d = ST_OWN_B;
                        end
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end

            ST_OWN_B: begin
                if (!REQ_B) begin
                    state_d = REQ_A ? ST_OWN_A : ST_IDLE;
                end else if (w_xfer) begin
                    if (w_burst_done) begin
                        cnt_d = '0;
                        if (REQ_A) begin
                            state_d = ST_OWN_A;
                        end
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any change of owner restarts the burst and records the new owner.
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == ST_OWN_A) begin
                last_d = 1'b0;
            end else if (state_d == ST_OWN_B) begin
                last_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        GNT_A = (state_q == ST_OWN_A);
        GNT_B = (state_q == ST_OWN_B);
        S     = (state_q == ST_OWN_B);
        VALID = w_valid;
    end

    mux2_bus #(
        .W (W)
    ) u_mux2_bus (
        .S (S),
        .A (DATA_A),
        .B (DATA_B),
        .X (DATA_X)
    );

endmodule : mux2_rr_arbiter
`default_nettype wire
